// File: rtl/sum_display_driver.sv
// sum_display_driver: converts an unsigned binary result to two decimal
// digits using shift-and-add-3 (one bit per cycle), then registers them
// as 9-bit seven-segment codes for the left (tens) and right (units)
// displays.
module sum_display_driver #(
    parameter int WIDTH    = 5,
    parameter int LZ_BLANK = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] binIn,
    input  logic             binValid,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [8:0]       segLeft,
    output logic [8:0]       segRight
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [8:0] SEG_BLANK = 9'h000;
    localparam logic [8:0] SEG_DASH  = 9'h040;
    localparam logic [8:0] SEG_ZERO  = 9'h03f;

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

    state_t          state, state_nx;
    logic [WIDTH-1:0] shreg;
    logic [3:0]      units, tens;
    logic            hund;
    logic [CW-1:0]   cnt;
    logic            ovf_pend;
    logic [3:0]      units_adj, tens_adj;
    logic            show_dash;

    function automatic logic [8:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 9'h03f;
            4'd1:    seg_code = 9'h006;
            4'd2:    seg_code = 9'h05b;
            4'd3:    seg_code = 9'h04f;
            4'd4:    seg_code = 9'h066;
            4'd5:    seg_code = 9'h06d;
            4'd6:    seg_code = 9'h07d;
            4'd7:    seg_code = 9'h007;
            4'd8:    seg_code = 9'h07f;
            4'd9:    seg_code = 9'h06f;
            default: seg_code = SEG_DASH;
        endcase
    endfunction

    // Add-3 correction applied to each BCD digit before it is shifted.
    always_comb begin
        units_adj = (units >= 4'd5) ? units + 4'd3 : units;
        tens_adj  = (tens  >= 4'd5) ? tens  + 4'd3 : tens;
    end

    // The hundreds carry and the pending flag agree for every legal width;
    // either one selects the dash display.
    assign show_dash = ovf_pend | hund;
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state logic: one SHIFT cycle per input bit, then a single UPDATE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (binValid) state_nx = SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_nx = UPDATE;
            UPDATE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Conversion datapath and registered display outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg    <= '0;
            units    <= '0;
            tens     <= '0;
            hund     <= 1'b0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            segLeft  <= SEG_ZERO;
            segRight <= SEG_ZERO;
        end else begin
            done <= (state == UPDATE);
            case (state)
                IDLE: begin
                    if (binValid) begin
                        shreg    <= binIn;
                        units    <= '0;
                        tens     <= '0;
                        hund     <= 1'b0;
                        cnt      <= CW'(WIDTH);
                        ovf_pend <= ({{(8-WIDTH){1'b0}}, binIn} > 8'd99);
                    end
                end
                SHIFT: begin
                    hund  <= tens_adj[3];
                    tens  <= {tens_adj[2:0], units_adj[3]};
                    units <= {units_adj[2:0], shreg[WIDTH-1]};
                    shreg <= shreg << 1;
                    cnt   <= cnt - CW'(1);
                end
                UPDATE: begin
                    if (show_dash) begin
                        segLeft  <= SEG_DASH;
                        segRight <= SEG_DASH;
                        overflow <= 1'b1;
                    end else begin
                        segRight <= seg_code(units);
                        segLeft  <= (LZ_BLANK != 0 && tens == 4'd0) ? SEG_BLANK
                                                                    : seg_code(tens);
                        overflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_display_driver.sv
// Bench for sum_display_driver: three instances (W5 leading-zero shown,
// W5 leading-zero blanked, W7) checked every cycle against a timer-based
// model, plus literal expectations on the displayed codes.
module tb_sum_display_driver;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [2:0][6:0] bin = '0;
    logic [2:0]      vld = '0;
    logic [2:0]      busy_o, done_o, ovf_o;
    logic [2:0][8:0] sl, sr;

    int nvec = 0;
    int nmis = 0;

    int W  [3] = '{5, 5, 7};
    int LZ [3] = '{0, 1, 0};
    logic [8:0] dig [10] = '{9'h03f, 9'h006, 9'h05b, 9'h04f, 9'h066,
                             9'h06d, 9'h07d, 9'h007, 9'h07f, 9'h06f};

    always #5 clk = ~clk;

    sum_display_driver #(.WIDTH(5), .LZ_BLANK(0)) u0 (
        .clk(clk), .rst(rst), .binIn(bin[0][4:0]), .binValid(vld[0]),
        .busy(busy_o[0]), .done(done_o[0]), .overflow(ovf_o[0]),
        .segLeft(sl[0]), .segRight(sr[0]));
    sum_display_driver #(.WIDTH(5), .LZ_BLANK(1)) u1 (
        .clk(clk), .rst(rst), .binIn(bin[1][4:0]), .binValid(vld[1]),
        .busy(busy_o[1]), .done(done_o[1]), .overflow(ovf_o[1]),
        .segLeft(sl[1]), .segRight(sr[1]));
    sum_display_driver #(.WIDTH(7), .LZ_BLANK(0)) u2 (
        .clk(clk), .rst(rst), .binIn(bin[2]), .binValid(vld[2]),
        .busy(busy_o[2]), .done(done_o[2]), .overflow(ovf_o[2]),
        .segLeft(sl[2]), .segRight(sr[2]));

    // Model: an accepted value shows up WIDTH+1 edges later; until then busy.
    int         mcnt [3];
    int         mval [3];
    logic [8:0] esl [3], esr [3];
    logic       eovf [3], edone [3];

    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                mcnt[i] = 0; esl[i] = 9'h03f; esr[i] = 9'h03f;
                eovf[i] = 1'b0; edone[i] = 1'b0;
            end else begin
                edone[i] = 1'b0;
                if (mcnt[i] == 0) begin
                    if (vld[i]) begin
                        mcnt[i] = W[i] + 1;
                        mval[i] = int'(bin[i]) % (1 << W[i]);
                    end
                end else begin
                    mcnt[i]--;
                    if (mcnt[i] == 0) begin
                        edone[i] = 1'b1;
                        if (mval[i] > 99) begin
                            esl[i] = 9'h040; esr[i] = 9'h040; eovf[i] = 1'b1;
                        end else begin
                            esr[i]  = dig[mval[i] % 10];
                            esl[i]  = (LZ[i] != 0 && mval[i] / 10 == 0) ? 9'h000
                                                                        : dig[mval[i] / 10];
                            eovf[i] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("busy%0d", i), int'(busy_o[i]), (mcnt[i] > 0) ? 1 : 0);
            chk($sformatf("done%0d", i), int'(done_o[i]), int'(edone[i]));
            chk($sformatf("ovf%0d", i),  int'(ovf_o[i]),  int'(eovf[i]));
            chk($sformatf("segL%0d", i), int'(sl[i]),     int'(esl[i]));
            chk($sformatf("segR%0d", i), int'(sr[i]),     int'(esr[i]));
        end
    end

    task automatic pulse(input int i, input int v);
        @(posedge clk); #2;
        bin[i] = v[6:0]; vld[i] = 1'b1;
        @(posedge clk); #2;
        vld[i] = 1'b0;
    endtask

    // Waits (bounded) for done; n = negedges waited, nb = negedges with busy.
    task automatic wait_done(input int i, output int n, output int nb);
        n = 0; nb = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (busy_o[i]) nb++;
            if (done_o[i]) break;
        end
        if (!done_o[i]) begin
            nvec++; nmis++;
            $display("FAIL timeout%0d: done not seen within %0d cycles", i, n);
        end
    endtask

    task automatic conv(input int i, input int v, input int el, input int er, input int eo);
        int n, nb;
        pulse(i, v);
        wait_done(i, n, nb);
        chk($sformatf("lit_segL%0d_v%0d", i, v), int'(sl[i]), el);
        chk($sformatf("lit_segR%0d_v%0d", i, v), int'(sr[i]), er);
        chk($sformatf("lit_ovf%0d_v%0d", i, v),  int'(ovf_o[i]), eo);
        chk($sformatf("lit_busycyc%0d_v%0d", i, v), nb, W[i] + 1);
        @(negedge clk);
        chk($sformatf("lit_donedrop%0d_v%0d", i, v), int'(done_o[i]), 0);
    endtask

    initial begin
        int n, nb, nd;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("lit_rst_segL%0d", i), int'(sl[i]), 9'h03f);
            chk($sformatf("lit_rst_segR%0d", i), int'(sr[i]), 9'h03f);
            chk($sformatf("lit_rst_busy%0d", i), int'(busy_o[i]), 0);
        end
        @(posedge clk); #2 rst = 1'b1;

        // Basic conversions
        conv(0, 27, 9'h05b, 9'h007, 0);
        conv(0, 9,  9'h03f, 9'h06f, 0);
        conv(1, 0,  9'h000, 9'h03f, 0);
        conv(1, 9,  9'h000, 9'h06f, 0);
        conv(1, 31, 9'h04f, 9'h006, 0);
        conv(2, 99, 9'h06f, 9'h06f, 0);
        conv(2, 100, 9'h040, 9'h040, 1);
        conv(2, 127, 9'h040, 9'h040, 1);
        conv(2, 0,  9'h03f, 9'h03f, 0);

        // Strobe while busy is dropped
        @(posedge clk); #2; bin[0] = 7'd30; vld[0] = 1'b1;
        @(posedge clk); #2; vld[0] = 1'b0;
        @(posedge clk);
        @(posedge clk); #2; bin[0] = 7'd5; vld[0] = 1'b1;
        @(posedge clk); #2; vld[0] = 1'b0;
        nd = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done_o[0]) nd++;
        end
        chk("lit_busy_drop_dones", nd, 1);
        chk("lit_busy_drop_segL", int'(sl[0]), 9'h04f);
        chk("lit_busy_drop_segR", int'(sr[0]), 9'h03f);

        // Reset during the third SHIFT cycle
        pulse(0, 12);
        @(posedge clk);
        @(posedge clk); #2 rst = 1'b0;
        #1;
        chk("lit_abort_segL", int'(sl[0]), 9'h03f);
        chk("lit_abort_segR", int'(sr[0]), 9'h03f);
        chk("lit_abort_busy", int'(busy_o[0]), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        nd = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done_o[0]) nd++;
        end
        chk("lit_abort_nodone", nd, 0);
        conv(0, 12, 9'h006, 9'h05b, 0);

        // Back-to-back with binValid held high
        @(posedge clk); #2; bin[0] = 7'd17; vld[0] = 1'b1;
        @(posedge clk); #2; bin[0] = 7'd21;
        wait_done(0, n, nb);
        chk("lit_b2b_segL17", int'(sl[0]), 9'h006);
        chk("lit_b2b_segR17", int'(sr[0]), 9'h007);
        wait_done(0, n, nb);
        vld[0] = 1'b0;
        chk("lit_b2b_period", n, 7);
        chk("lit_b2b_segL21", int'(sl[0]), 9'h05b);
        chk("lit_b2b_segR21", int'(sr[0]), 9'h006);
        repeat (12) @(negedge clk);
        chk("lit_b2b_idle", int'(busy_o[0]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
